// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder slice reused LSB-first over WIDTH cycles.
// Optional subtract mode (Sub port) when SERIAL_ADDER_SUB_EN is defined.
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] Data_in_A,
  input  logic [WIDTH-1:0] Data_in_B,
  input  logic             Data_in_C,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             Sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Data_out_Sum,
  output logic             Data_out_Carry
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-2:0] sum_sh;
  logic [WIDTH-1:0] next_sum;
  logic             carry_r;
  logic [CW-1:0]    cnt;
  logic             fa_b;
  logic             fa_sum;
  logic             fa_carry;
  logic             init_carry;

`ifdef SERIAL_ADDER_SUB_EN
  logic sub_r;
  assign fa_b       = b_sh[0] ^ sub_r;
  assign init_carry = Sub | Data_in_C;
`else
  assign fa_b       = b_sh[0];
  assign init_carry = Data_in_C;
`endif

  always_comb begin
    fa_sum   = a_sh[0] ^ fa_b ^ carry_r;
    fa_carry = (a_sh[0] & fa_b) | (carry_r & (a_sh[0] ^ fa_b));
  end

  // The slot a full WIDTH-bit sum register would use for its LSB only ever
  // holds a bit about to be discarded, so the stored part is WIDTH-1 bits.
  assign next_sum = {fa_sum, sum_sh};
  assign busy     = (state == S_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      a_sh           <= '0;
      b_sh           <= '0;
      sum_sh         <= '0;
      carry_r        <= 1'b0;
      cnt            <= '0;
      done           <= 1'b0;
      Data_out_Sum   <= '0;
      Data_out_Carry <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      sub_r          <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (state == S_IDLE) begin
        if (start) begin
          a_sh    <= Data_in_A;
          b_sh    <= Data_in_B;
          carry_r <= init_carry;
          cnt     <= '0;
`ifdef SERIAL_ADDER_SUB_EN
          sub_r   <= Sub;
`endif
          state   <= S_RUN;
        end
      end else begin
        a_sh    <= a_sh >> 1;
        b_sh    <= b_sh >> 1;
        sum_sh  <= next_sum[WIDTH-1:1];
        carry_r <= fa_carry;
        cnt     <= cnt + CW'(1);
        if (cnt == LAST) begin
          Data_out_Sum   <= next_sum;
          Data_out_Carry <= fa_carry;
          done           <= 1'b1;
          state          <= S_IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8) against an arithmetic reference model.
module tb_serial_adder_ctrl;
  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         c = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
  logic         sub = 1'b0;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .Data_in_A     (a),
    .Data_in_B     (b),
    .Data_in_C     (c),
`ifdef SERIAL_ADDER_SUB_EN
    .Sub           (sub),
`endif
    .busy          (busy),
    .done          (done),
    .Data_out_Sum  (sum),
    .Data_out_Carry(carry)
  );

  function automatic logic [W:0] add_model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    int unsigned r;
    r = int'(x) + int'(y) + (ci ? 1 : 0);
    return r[W:0];
  endfunction

  // Drives one add from the cycle before the accept edge; returns at #1 after the done edge.
  task automatic run_add(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                         output int lat, output int bcyc, output logic [W-1:0] s, output logic co);
    a = av; b = bv; c = cv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = W'($urandom); b = W'($urandom); c = 1'($urandom);
    bcyc = busy ? 1 : 0;
    lat  = 0;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (done) break;
      if (busy) bcyc++;
    end
    s  = sum;
    co = carry;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (sum !== '0) begin errors++; $display("FAIL reset_sum got %h want 00", sum); end
    checks++; if (carry !== 1'b0) begin errors++; $display("FAIL reset_carry got %b want 0", carry); end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
  endtask

  task automatic test_basic();
    int lat, bcyc; logic [W-1:0] s; logic co;
    run_add(8'h5A, 8'h3C, 1'b0, lat, bcyc, s, co);
    checks++; if (lat !== 8) begin errors++; $display("FAIL basic_latency got %0d want 8", lat); end
    checks++; if (bcyc !== 8) begin errors++; $display("FAIL basic_busy_cycles got %0d want 8", bcyc); end
    checks++; if (s !== 8'h96) begin errors++; $display("FAIL basic_sum got %h want 96", s); end
    checks++; if (co !== 1'b0) begin errors++; $display("FAIL basic_carry got %b want 0", co); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_one_cycle got %b want 0", done); end
    checks++; if (sum !== 8'h96) begin errors++; $display("FAIL sum_held got %h want 96", sum); end
  endtask

  task automatic test_corners();
    int lat, bcyc; logic [W-1:0] s; logic co;
    run_add(8'hFF, 8'h01, 1'b0, lat, bcyc, s, co);
    checks++; if ({co, s} !== 9'h100) begin errors++; $display("FAIL ff_plus_01 got %h want 100", {co, s}); end
    run_add(8'hFF, 8'hFF, 1'b1, lat, bcyc, s, co);
    checks++; if ({co, s} !== 9'h1FF) begin errors++; $display("FAIL ff_plus_ff_c1 got %h want 1ff", {co, s}); end
    checks++; if (lat !== 8) begin errors++; $display("FAIL corner_latency got %0d want 8", lat); end
  endtask

  task automatic test_random();
    int lat, bcyc; logic [W-1:0] s, x, y; logic co, ci; logic [W:0] exp;
    for (int i = 0; i < 24; i++) begin
      x = W'($urandom); y = W'($urandom); ci = 1'($urandom);
      exp = add_model(x, y, ci);
      run_add(x, y, ci, lat, bcyc, s, co);
      checks++; if ({co, s} !== exp) begin errors++; $display("FAIL rand_add %h+%h+%b got %h want %h", x, y, ci, {co, s}, exp); end
      checks++; if (lat !== 8) begin errors++; $display("FAIL rand_latency got %0d want 8", lat); end
    end
  endtask

  task automatic test_ignore_start();
    logic [W:0] prev; logic [W-1:0] s_done; logic c_done; int ndone, first_edge;
    prev = {carry, sum};
    a = 8'h01; b = 8'h01; c = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      checks++; if ({carry, sum} !== prev) begin errors++; $display("FAIL out_held_midrun got %h want %h", {carry, sum}, prev); end
    end
    a = 8'hAA; b = 8'h55; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    ndone = 0; first_edge = 0; s_done = '0; c_done = 1'b0;
    for (int e = 5; e <= 24; e++) begin
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        if (ndone == 1) begin first_edge = e; s_done = sum; c_done = carry; end
      end
    end
    checks++; if (ndone !== 1) begin errors++; $display("FAIL ignore_done_count got %0d want 1", ndone); end
    checks++; if (first_edge !== 8) begin errors++; $display("FAIL ignore_latency got %0d want 8", first_edge); end
    checks++; if ({c_done, s_done} !== 9'h002) begin errors++; $display("FAIL ignore_result got %h want 002", {c_done, s_done}); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] x, y; logic [W:0] exp1; int lat;
    x = W'($urandom); y = W'($urandom);
    exp1 = add_model(x, y, 1'b0);
    a = x; b = y; c = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = 8'h10; b = 8'h20;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk); #1; lat++;
      if (done) break;
    end
    checks++; if (lat !== 8) begin errors++; $display("FAIL b2b_first_latency got %0d want 8", lat); end
    checks++; if ({carry, sum} !== exp1) begin errors++; $display("FAIL b2b_first_result got %h want %h", {carry, sum}, exp1); end
    @(posedge clk); #1;
    start = 1'b0; a = W'($urandom); b = W'($urandom);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got busy %b want 1", busy); end
    lat = 0;
    while (lat < 40) begin
      @(posedge clk); #1; lat++;
      if (done) break;
      checks++; if ({carry, sum} !== exp1) begin errors++; $display("FAIL b2b_held got %h want %h", {carry, sum}, exp1); end
    end
    checks++; if (lat !== 8) begin errors++; $display("FAIL b2b_second_latency got %0d want 8", lat); end
    checks++; if ({carry, sum} !== 9'h030) begin errors++; $display("FAIL b2b_second_result got %h want 030", {carry, sum}); end
  endtask

  task automatic test_reset_mid();
    int lat, bcyc, ndone; logic [W-1:0] s; logic co;
    a = 8'h7F; b = 8'h01; c = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b want 0", busy); end
    checks++; if ({carry, sum} !== 9'h000) begin errors++; $display("FAIL midreset_out got %h want 000", {carry, sum}); end
    @(negedge clk); rst_n = 1'b1;
    ndone = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    checks++; if (ndone !== 0) begin errors++; $display("FAIL midreset_done got %0d pulses want 0", ndone); end
    run_add(8'h7F, 8'h01, 1'b0, lat, bcyc, s, co);
    checks++; if ({co, s} !== 9'h080) begin errors++; $display("FAIL post_reset_add got %h want 080", {co, s}); end
    checks++; if (lat !== 8) begin errors++; $display("FAIL post_reset_latency got %0d want 8", lat); end
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub();
    int lat, bcyc; logic [W-1:0] s, x, y; logic co;
    sub = 1'b1;
    run_add(8'h10, 8'h01, 1'b0, lat, bcyc, s, co);
    checks++; if ({co, s} !== 9'h10F) begin errors++; $display("FAIL sub_10_01 got %h want 10f", {co, s}); end
    sub = 1'b1;
    run_add(8'h01, 8'h02, 1'b1, lat, bcyc, s, co);
    checks++; if ({co, s} !== 9'h0FF) begin errors++; $display("FAIL sub_01_02 got %h want 0ff", {co, s}); end
    for (int i = 0; i < 8; i++) begin
      x = W'($urandom); y = W'($urandom);
      sub = 1'b1;
      run_add(x, y, 1'($urandom), lat, bcyc, s, co);
      checks++; if ({co, s} !== {(x >= y), W'(x - y)}) begin errors++; $display("FAIL sub_rand %h-%h got %h want %h", x, y, {co, s}, {(x >= y), W'(x - y)}); end
    end
    sub = 1'b0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
